// File: rtl/e203_fpu_reqrsp_slv.sv
// FPU-side endpoint of the ALU-to-FPU Req/Rsp channel: one request in flight, start/done datapath launch, watchdog.
// Optional macro E203_FPU_REQRSP_B2B_EN lets a new request be accepted in the response hand-off cycle.
`ifndef E203_FLEN
`define E203_FLEN 32
`endif
`ifndef E203_DECINFO_WIDTH
`define E203_DECINFO_WIDTH 32
`endif

module e203_fpu_reqrsp_slv #(
  parameter int FLEN    = `E203_FLEN,
  parameter int IW      = `E203_DECINFO_WIDTH,
  parameter int EXE_TMO = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            fpu_req_valid,
  output logic            fpu_req_ready,
  input  logic [FLEN-1:0] fpu_req_rs1,
  input  logic [FLEN-1:0] fpu_req_rs2,
  input  logic [FLEN-1:0] fpu_req_rs3,
  input  logic [IW-1:0]   fpu_req_info,
  output logic            fpu_rsp_valid,
  input  logic            fpu_rsp_ready,
  output logic [FLEN-1:0] fpu_rsp_wdat,
  output logic [4:0]      fpu_rsp_fflags,
  output logic            fpu_rsp_err,
  output logic            exe_o_start,
  output logic [FLEN-1:0] exe_o_rs1,
  output logic [FLEN-1:0] exe_o_rs2,
  output logic [FLEN-1:0] exe_o_rs3,
  output logic [IW-1:0]   exe_o_info,
  input  logic            exe_i_done,
  input  logic [FLEN-1:0] exe_i_result,
  input  logic [4:0]      exe_i_fflags
);

  localparam int CW = $clog2(EXE_TMO + 1);
  localparam logic [CW-1:0] TMO_LAST = CW'(EXE_TMO - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RSP  = 2'd2
  } state_t;

  state_t          state_r, state_s;
  logic [CW-1:0]   cnt_r, cnt_s;
  logic            start_s;
  logic [FLEN-1:0] wdat_s;
  logic [4:0]      fflags_s;
  logic            err_s;

  // Ready is a pure state decode, except for the hand-off path in back-to-back mode.
`ifdef E203_FPU_REQRSP_B2B_EN
  assign fpu_req_ready = (state_r == ST_IDLE) | ((state_r == ST_RSP) & fpu_rsp_ready);
`else
  assign fpu_req_ready = (state_r == ST_IDLE);
`endif

  // Next-state, watchdog count and response capture.
  always_comb begin
    state_s  = state_r;
    cnt_s    = {CW{1'b0}};
    start_s  = 1'b0;
    wdat_s   = fpu_rsp_wdat;
    fflags_s = fpu_rsp_fflags;
    err_s    = fpu_rsp_err;
    case (state_r)
      ST_IDLE: begin
        if (fpu_req_valid) begin
          state_s = ST_EXEC;
          start_s = 1'b1;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_EXEC: begin
        // A done arriving on the timeout cycle still delivers the real result.
        if (exe_i_done) begin
          state_s  = ST_RSP;
          wdat_s   = exe_i_result;
          fflags_s = exe_i_fflags;
          err_s    = 1'b0;
        end else if (cnt_r == TMO_LAST) begin
          state_s  = ST_RSP;
          wdat_s   = {FLEN{1'b0}};
          fflags_s = 5'b10000;
          err_s    = 1'b1;
        end else begin
          state_s  = ST_EXEC;
          cnt_s    = cnt_r + CW'(1);
        end
      end
      ST_RSP: begin
        if (fpu_rsp_ready) begin
`ifdef E203_FPU_REQRSP_B2B_EN
          if (fpu_req_valid) begin
            state_s = ST_EXEC;
            start_s = 1'b1;
          end else begin
            state_s = ST_IDLE;
          end
`else
          state_s = ST_IDLE;
`endif
        end else begin
          state_s = ST_RSP;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // State, operand and response registers; start_s doubles as the accept strobe.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r        <= ST_IDLE;
      cnt_r          <= {CW{1'b0}};
      exe_o_start    <= 1'b0;
      exe_o_rs1      <= {FLEN{1'b0}};
      exe_o_rs2      <= {FLEN{1'b0}};
      exe_o_rs3      <= {FLEN{1'b0}};
      exe_o_info     <= {IW{1'b0}};
      fpu_rsp_valid  <= 1'b0;
      fpu_rsp_wdat   <= {FLEN{1'b0}};
      fpu_rsp_fflags <= 5'b00000;
      fpu_rsp_err    <= 1'b0;
    end else begin
      state_r        <= state_s;
      cnt_r          <= cnt_s;
      exe_o_start    <= start_s;
      fpu_rsp_valid  <= (state_s == ST_RSP);
      fpu_rsp_wdat   <= wdat_s;
      fpu_rsp_fflags <= fflags_s;
      fpu_rsp_err    <= err_s;
      if (start_s) begin
        exe_o_rs1  <= fpu_req_rs1;
        exe_o_rs2  <= fpu_req_rs2;
        exe_o_rs3  <= fpu_req_rs3;
        exe_o_info <= fpu_req_info;
      end else begin
        exe_o_rs1  <= exe_o_rs1;
        exe_o_rs2  <= exe_o_rs2;
        exe_o_rs3  <= exe_o_rs3;
        exe_o_info <= exe_o_info;
      end
    end
  end

endmodule

// File: tb/tb_e203_fpu_reqrsp_slv.sv
// Directed, table-driven bench for e203_fpu_reqrsp_slv plus hand-written multi-cycle corner sequences.
module tb_e203_fpu_reqrsp_slv;

  logic        clk = 1'b0;
  logic        rst;
  logic        fpu_req_valid, fpu_req_ready;
  logic [31:0] fpu_req_rs1, fpu_req_rs2, fpu_req_rs3, fpu_req_info;
  logic        fpu_rsp_valid, fpu_rsp_ready;
  logic [31:0] fpu_rsp_wdat;
  logic [4:0]  fpu_rsp_fflags;
  logic        fpu_rsp_err;
  logic        exe_o_start;
  logic [31:0] exe_o_rs1, exe_o_rs2, exe_o_rs3, exe_o_info;
  logic        exe_i_done;
  logic [31:0] exe_i_result;
  logic [4:0]  exe_i_fflags;

  always #5 clk = ~clk;

  e203_fpu_reqrsp_slv #(.FLEN(32), .IW(32), .EXE_TMO(64)) dut (
    .clk(clk), .rst(rst),
    .fpu_req_valid(fpu_req_valid), .fpu_req_ready(fpu_req_ready),
    .fpu_req_rs1(fpu_req_rs1), .fpu_req_rs2(fpu_req_rs2), .fpu_req_rs3(fpu_req_rs3),
    .fpu_req_info(fpu_req_info),
    .fpu_rsp_valid(fpu_rsp_valid), .fpu_rsp_ready(fpu_rsp_ready),
    .fpu_rsp_wdat(fpu_rsp_wdat), .fpu_rsp_fflags(fpu_rsp_fflags), .fpu_rsp_err(fpu_rsp_err),
    .exe_o_start(exe_o_start),
    .exe_o_rs1(exe_o_rs1), .exe_o_rs2(exe_o_rs2), .exe_o_rs3(exe_o_rs3), .exe_o_info(exe_o_info),
    .exe_i_done(exe_i_done), .exe_i_result(exe_i_result), .exe_i_fflags(exe_i_fflags)
  );

  typedef struct {
    logic [31:0] rs1, rs2, rs3, info;
    int          k;        // cycles after start before done; -1 = never
    logic [31:0] res;
    logic [4:0]  ff;
    int          hold;     // cycles of rsp backpressure
    logic [31:0] exp_wdat;
    logic [4:0]  exp_ff;
    logic        exp_err;
    int          exp_lat;  // start cycle to first rsp_valid cycle
  } vec_t;

  vec_t vt[6];
  int   n_cmp = 0;
  int   n_err = 0;

`ifdef E203_FPU_REQRSP_B2B_EN
  localparam int SPACING = 3;
`else
  localparam int SPACING = 4;
`endif

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Called at a negedge in IDLE; returns at a negedge with the response pending.
  task automatic launch(input vec_t v);
    int cyc;
    int extra;
    bit got;
    chk("req_ready_idle", 32'(fpu_req_ready), 32'd1);
    fpu_req_valid = 1'b1;
    fpu_req_rs1 = v.rs1; fpu_req_rs2 = v.rs2; fpu_req_rs3 = v.rs3; fpu_req_info = v.info;
    @(negedge clk);
    fpu_req_valid = 1'b0;
    chk("start_pulse", 32'(exe_o_start), 32'd1);
    chk("exe_rs1", exe_o_rs1, v.rs1);
    chk("exe_rs2", exe_o_rs2, v.rs2);
    chk("exe_rs3", exe_o_rs3, v.rs3);
    chk("exe_info", exe_o_info, v.info);
    cyc = 0; extra = 0; got = 1'b0;
    while (!got && cyc < 200) begin
      exe_i_done   = (cyc == v.k);
      exe_i_result = v.res;
      exe_i_fflags = v.ff;
      @(negedge clk);
      exe_i_done = 1'b0;
      cyc++;
      if (exe_o_start) extra++;
      if (fpu_rsp_valid) got = 1'b1;
    end
    chk("rsp_latency", cyc, v.exp_lat);
    chk("extra_start", extra, 32'd0);
    chk("rsp_wdat", fpu_rsp_wdat, v.exp_wdat);
    chk("rsp_fflags", 32'(fpu_rsp_fflags), 32'(v.exp_ff));
    chk("rsp_err", 32'(fpu_rsp_err), 32'(v.exp_err));
    chk("req_ready_busy", 32'(fpu_req_ready), 32'd0);
    for (int h = 0; h < v.hold; h++) begin
      exe_i_done = 1'b1; exe_i_result = 32'hBAD0BAD0; exe_i_fflags = 5'h1F;
      @(negedge clk);
      exe_i_done = 1'b0;
      chk("hold_valid", 32'(fpu_rsp_valid), 32'd1);
      chk("hold_wdat", fpu_rsp_wdat, v.exp_wdat);
      chk("hold_fflags", 32'(fpu_rsp_fflags), 32'(v.exp_ff));
    end
  endtask

  task automatic finish_rsp();
    fpu_rsp_ready = 1'b1;
    @(negedge clk);
    fpu_rsp_ready = 1'b0;
    chk("rsp_drop", 32'(fpu_rsp_valid), 32'd0);
    chk("req_ready_back", 32'(fpu_req_ready), 32'd1);
  endtask

  initial begin
    int nacc;
    int acc[8];
    int vcnt;
    bit prev_start;

    vt[0] = '{32'h3F800000, 32'h40000000, 32'h0, 32'h1, 3, 32'h40400000, 5'b00000, 0,
              32'h40400000, 5'b00000, 1'b0, 4};
    vt[1] = '{32'h11111111, 32'h22222222, 32'h33333333, 32'hA5, 0, 32'h12345678, 5'b00001, 2,
              32'h12345678, 5'b00001, 1'b0, 1};
    vt[2] = '{32'h1, 32'h2, 32'h3, 32'hFFFFFFFF, 7, 32'hDEADBEEF, 5'b00100, 0,
              32'hDEADBEEF, 5'b00100, 1'b0, 8};
    vt[3] = '{32'h7F800000, 32'h0, 32'h55, 32'h9, -1, 32'h12121212, 5'b00011, 3,
              32'h0, 5'b10000, 1'b1, 64};
    vt[4] = '{32'h4, 32'h5, 32'h6, 32'h7, 62, 32'hCAFEF00D, 5'b01000, 0,
              32'hCAFEF00D, 5'b01000, 1'b0, 63};
    vt[5] = '{32'h8, 32'h9, 32'hA, 32'hB, 63, 32'h0BADF00D, 5'b00010, 0,
              32'h0BADF00D, 5'b00010, 1'b0, 64};

    rst = 1'b1; fpu_req_valid = 1'b0; fpu_rsp_ready = 1'b0;
    fpu_req_rs1 = 32'h0; fpu_req_rs2 = 32'h0; fpu_req_rs3 = 32'h0; fpu_req_info = 32'h0;
    exe_i_done = 1'b0; exe_i_result = 32'h0; exe_i_fflags = 5'b00000;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_req_ready", 32'(fpu_req_ready), 32'd1);
    chk("rst_rsp_valid", 32'(fpu_rsp_valid), 32'd0);
    chk("rst_start", 32'(exe_o_start), 32'd0);
    chk("rst_wdat", fpu_rsp_wdat, 32'h0);
    chk("rst_exe_rs1", exe_o_rs1, 32'h0);

    for (int i = 0; i < 6; i++) begin
      launch(vt[i]);
      finish_rsp();
    end

    // Stray done while idle must not create a response.
    exe_i_done = 1'b1; exe_i_result = 32'h77777777; exe_i_fflags = 5'b11111;
    @(negedge clk);
    exe_i_done = 1'b0;
    chk("stray_rsp_valid", 32'(fpu_rsp_valid), 32'd0);
    chk("stray_req_ready", 32'(fpu_req_ready), 32'd1);
    chk("stray_start", 32'(exe_o_start), 32'd0);

    // Backpressure with a competing request held valid.
    launch(vt[0]);
    fpu_req_valid = 1'b1;
    fpu_req_rs1 = 32'hAAAA0001; fpu_req_rs2 = 32'hAAAA0002; fpu_req_rs3 = 32'hAAAA0003; fpu_req_info = 32'h2;
    for (int h = 0; h < 10; h++) begin
      exe_i_done = 1'b1; exe_i_result = 32'h55555555; exe_i_fflags = 5'b11111;
      @(negedge clk);
      exe_i_done = 1'b0;
      chk("bp_valid", 32'(fpu_rsp_valid), 32'd1);
      chk("bp_wdat", fpu_rsp_wdat, 32'h40400000);
      chk("bp_fflags", 32'(fpu_rsp_fflags), 32'd0);
      chk("bp_req_ready", 32'(fpu_req_ready), 32'd0);
      chk("bp_exe_rs1", exe_o_rs1, 32'h3F800000);
    end
    fpu_rsp_ready = 1'b1;
    @(negedge clk);
    fpu_rsp_ready = 1'b0;
`ifdef E203_FPU_REQRSP_B2B_EN
    fpu_req_valid = 1'b0;
`else
    chk("bp_rsp_drop", 32'(fpu_rsp_valid), 32'd0);
    chk("bp_no_start_yet", 32'(exe_o_start), 32'd0);
    @(negedge clk);
    fpu_req_valid = 1'b0;
`endif
    chk("bp_second_start", 32'(exe_o_start), 32'd1);
    chk("bp_second_rs1", exe_o_rs1, 32'hAAAA0001);
    exe_i_done = 1'b1; exe_i_result = 32'h13579BDF; exe_i_fflags = 5'b00001;
    @(negedge clk);
    exe_i_done = 1'b0;
    chk("same_cycle_done_valid", 32'(fpu_rsp_valid), 32'd1);
    chk("same_cycle_done_wdat", fpu_rsp_wdat, 32'h13579BDF);
    finish_rsp();

    // Reset while in EXEC: no later response, even past the watchdog limit.
    fpu_req_valid = 1'b1;
    @(negedge clk);
    fpu_req_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rexec_req_ready", 32'(fpu_req_ready), 32'd1);
    chk("rexec_rsp_valid", 32'(fpu_rsp_valid), 32'd0);
    chk("rexec_start", 32'(exe_o_start), 32'd0);
    vcnt = 0;
    for (int c = 0; c < 70; c++) begin
      @(negedge clk);
      if (fpu_rsp_valid) vcnt++;
    end
    chk("rexec_no_rsp", vcnt, 32'd0);

    // Reset while in RSP discards the response.
    launch(vt[1]);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rrsp_rsp_valid", 32'(fpu_rsp_valid), 32'd0);
    chk("rrsp_req_ready", 32'(fpu_req_ready), 32'd1);
    chk("rrsp_wdat", fpu_rsp_wdat, 32'h0);
    launch(vt[0]);
    finish_rsp();

    // Throughput: datapath answers one cycle after start, rsp_ready held high.
    fpu_req_valid = 1'b1; fpu_rsp_ready = 1'b1;
    prev_start = 1'b0; nacc = 0;
    for (int c = 0; c < 30; c++) begin
      if (fpu_req_ready && nacc < 8) begin
        acc[nacc] = c;
        nacc++;
      end
      exe_i_done = prev_start; exe_i_result = 32'(c); exe_i_fflags = 5'b00000;
      prev_start = exe_o_start;
      @(negedge clk);
    end
    fpu_req_valid = 1'b0; fpu_rsp_ready = 1'b0; exe_i_done = 1'b0;
    chk("accept_count", (nacc >= 5) ? 32'd1 : 32'd0, 32'd1);
    for (int i = 1; i < 5; i++) begin
      chk("req_spacing", acc[i] - acc[i-1], SPACING);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
